// File: rtl/lnzd_index_scheduler.sv
// Turns nonzero group masks into absolute element indices, highest bit first, one index per cycle.
// Latency 1 from mask to first index; the index holds under !idx_ready, and the next mask is taken while idle or alongside the last index.
module lnzd_index_scheduler #(
  parameter  int BIT_WIDTH = 8,
  parameter  int NUM_GROUP = 4,
  localparam int IDX_WIDTH = $clog2(BIT_WIDTH * NUM_GROUP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mask_valid,
  output logic                 mask_ready,
  input  logic [BIT_WIDTH-1:0] mask_data,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic [IDX_WIDTH-1:0] idx_data,
  output logic                 idx_last,
  output logic                 vec_done,
  output logic                 busy
);

  localparam int POS_W = $clog2(BIT_WIDTH);
  localparam int GRP_W = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUP - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] residual;
  logic [GRP_W-1:0]     group;
  logic                 vec_done_q;

  logic [POS_W-1:0]     pos;
  logic                 single_bit;
  logic                 idx_fire;
  logic                 mask_fire;
  logic                 mask_nz;
  logic [GRP_W-1:0]     grp_inc1;
  logic [GRP_W-1:0]     grp_inc2;

  // Leading nonzero detector: the highest set bit wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (residual[i]) pos = POS_W'(i);
    end
  end

  assign single_bit = (residual != '0) && ((residual & (residual - BIT_WIDTH'(1))) == '0);

  assign busy      = (state == ISSUE);
  assign idx_valid = busy;
  assign idx_last  = busy && single_bit;
  assign idx_data  = busy ? ((IDX_WIDTH'(group) << POS_W) | IDX_WIDTH'(pos)) : '0;
  assign vec_done  = vec_done_q;

  assign idx_fire   = idx_valid && idx_ready;
  assign mask_ready = (state == IDLE) || (idx_fire && idx_last);
  assign mask_fire  = mask_valid && mask_ready;
  assign mask_nz    = (mask_data != '0);

  assign grp_inc1 = (group == LAST_GRP)    ? '0 : group + GRP_W'(1);
  assign grp_inc2 = (grp_inc1 == LAST_GRP) ? '0 : grp_inc1 + GRP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      residual   <= '0;
      group      <= '0;
      vec_done_q <= 1'b0;
    end else begin
      vec_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mask_fire) begin
            if (mask_nz) begin
              residual <= mask_data;
              state    <= ISSUE;
            end else begin
              group      <= grp_inc1;
              vec_done_q <= (group == LAST_GRP);
            end
          end
        end
        ISSUE: begin
          if (idx_fire) begin
            if (single_bit) begin
              if (mask_fire && mask_nz) begin
                residual   <= mask_data;
                group      <= grp_inc1;
                vec_done_q <= (group == LAST_GRP);
              end else if (mask_fire) begin
                // A zero mask taken alongside the last index completes a second group.
                residual   <= '0;
                state      <= IDLE;
                group      <= grp_inc2;
                vec_done_q <= (group == LAST_GRP) || (grp_inc1 == LAST_GRP);
              end else begin
                residual   <= '0;
                state      <= IDLE;
                group      <= grp_inc1;
                vec_done_q <= (group == LAST_GRP);
              end
            end else begin
              residual <= residual & ~(BIT_WIDTH'(1) << pos);
            end
          end
        end
        default: begin
          state    <= IDLE;
          residual <= '0;
        end
      endcase
    end
  end

endmodule
